rtc_wr_sched: RTL and testbench

RTC_WR_SCHED -- requirements
Module: rtc_wr_sched

---
 rtl/rtc_pkg.sv | 37 +++
 rtl/rtc_wr_sched_if.sv | 24 ++
 rtl/rtc_cyc_timer.sv | 35 +++
 rtl/rtc_wr_sched.sv | 181 ++++++++++++++++++
 tb/tb_rtc_wr_sched.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_pkg.sv
// Shared RTC definitions: scheduler state encoding, transaction source and the
// DS3231M power-up register table walked by the init sequence.
package rtc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    typedef enum logic {
        SRC_INIT = 1'b0,
        SRC_EXT  = 1'b1
    } src_t;

    localparam int INIT_LEN = 4;
    localparam int IDX_W    = 2;
    localparam int TMR_W    = 16;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] dat;
    } init_entry_t;

    function automatic init_entry_t init_entry(input logic [IDX_W-1:0] idx);
        init_entry_t e;
        case (idx)
            2'd0:    e = '{addr: 8'h0E, dat: 8'h1C};
            2'd1:    e = '{addr: 8'h0F, dat: 8'h00};
            2'd2:    e = '{addr: 8'h0A, dat: 8'h00};
            default: e = '{addr: 8'h0D, dat: 8'h00};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/rtc_wr_sched_if.sv
// Requester and write-engine signals of the RTC write scheduler; master is the
// scheduler side, slave is the requester/engine side.
interface rtc_wr_sched_if;
    logic       ext_req;
    logic [7:0] ext_addr;
    logic [7:0] ext_dat;
    logic       ext_ack;
    logic       ext_err;
    logic       eng_start;
    logic       eng_over;
    logic [7:0] eng_devaddr;
    logic [7:0] eng_wradd;
    logic [7:0] eng_wrdat;

    modport master (
        input  ext_req, ext_addr, ext_dat, eng_over,
        output ext_ack, ext_err, eng_start, eng_devaddr, eng_wradd, eng_wrdat
    );

    modport slave (
        output ext_req, ext_addr, ext_dat, eng_over,
        input  ext_ack, ext_err, eng_start, eng_devaddr, eng_wradd, eng_wrdat
    );
endinterface

// File: rtl/rtc_cyc_timer.sv
// Loadable down-counter shared by the timeout and inter-transaction gap;
// tc is high while the count sits at zero.
module rtc_cyc_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/rtc_wr_sched.sv
// Schedules single-register writes to the DS3231M engine: the init table on
// init_go, then external single writes, with a timeout and idle gap per write.
// state | meaning
// IDLE  | no transaction; pending init entries win over ext_req
// ISSUE | latch operands, arm timeout
// WAIT  | eng_start high until eng_over or timeout
// GAP   | bus-idle spacing, completion reported on exit
module rtc_wr_sched
    import rtc_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR    = 8'hD0,
    parameter int         GAP_CYC     = 16,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_go,
    rtc_wr_sched_if.master        bus,
    output logic                  busy,
    output logic                  init_done,
    output logic                  err,
    output logic [7:0]            err_cnt
);

    localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INIT_LEN - 1);

    state_t           state_q, state_d;
    src_t             src_q, src_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pend_q, pend_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [7:0]       wradd_q, wradd_d;
    logic [7:0]       wrdat_q, wrdat_d;
    logic             to_q, to_d;
    logic             ack_seen_q, ack_seen_d;

    logic             tmr_load, tmr_en, tmr_tc;
    logic [TMR_W-1:0] tmr_val;
    logic             ext_ack_w;
    init_entry_t      entry;

    rtc_cyc_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .tc       (tmr_tc)
    );

    assign entry     = init_entry(idx_q);
    assign ext_ack_w = (state_q == ST_GAP) && tmr_tc && (src_q == SRC_EXT);

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        idx_d      = idx_q;
        pend_d     = pend_q;
        done_d     = done_q;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;
        wradd_d    = wradd_q;
        wrdat_d    = wrdat_q;
        to_d       = to_q;
        ack_seen_d = ext_ack_w;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d = ST_ISSUE;
                    src_d   = SRC_INIT;
                end else if (bus.ext_req && !ack_seen_q) begin
                    // requester may still hold ext_req the cycle after its ack
                    state_d = ST_ISSUE;
                    src_d   = SRC_EXT;
                end
            end
            ST_ISSUE: begin
                if (src_q == SRC_INIT) begin
                    wradd_d = entry.addr;
                    wrdat_d = entry.dat;
                end else begin
                    wradd_d = bus.ext_addr;
                    wrdat_d = bus.ext_dat;
                end
                to_d     = 1'b0;
                tmr_load = 1'b1;
                tmr_val  = TO_LOAD;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                tmr_en = 1'b1;
                if (bus.eng_over) begin
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                    state_d  = ST_GAP;
                end else if (tmr_tc) begin
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                    to_d     = 1'b1;
                    err_d    = 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    state_d = ST_IDLE;
                    if (src_q == SRC_INIT) begin
                        // a timed-out entry still advances the walk
                        if (idx_q == IDX_LAST) begin
                            pend_d = 1'b0;
                            done_d = 1'b1;
                            idx_d  = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (init_go && !pend_q) begin
            pend_d = 1'b1;
            idx_d  = '0;
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_INIT;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= 8'd0;
            wradd_q    <= 8'd0;
            wrdat_q    <= 8'd0;
            to_q       <= 1'b0;
            ack_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            wradd_q    <= wradd_d;
            wrdat_q    <= wrdat_d;
            to_q       <= to_d;
            ack_seen_q <= ack_seen_d;
        end
    end

    assign bus.eng_start   = (state_q == ST_WAIT);
    assign bus.eng_devaddr = DEV_ADDR;
    assign bus.eng_wradd   = wradd_q;
    assign bus.eng_wrdat   = wrdat_q;
    assign bus.ext_ack     = ext_ack_w;
    assign bus.ext_err     = ext_ack_w & to_q;

    assign busy      = (state_q != ST_IDLE);
    assign init_done = done_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_rtc_wr_sched.sv
// Directed bench for rtc_wr_sched: engine model with a scoreboard of expected
// operands, plus a short-timeout instance for err_cnt saturation.
module tb_rtc_wr_sched;

    localparam int OVER_DELAY = 70;
    localparam int GAP        = 16;
    localparam int TMO        = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       init_go, init_go2;
    logic       busy, init_done, err;
    logic [7:0] err_cnt;
    logic       busy2, init_done2, err2;
    logic [7:0] err_cnt2;

    rtc_wr_sched_if bus ();
    rtc_wr_sched_if bus2 ();

    always #5 clk = ~clk;

    rtc_wr_sched dut (
        .clk       (clk),
        .rst       (rst),
        .init_go   (init_go),
        .bus       (bus),
        .busy      (busy),
        .init_done (init_done),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    rtc_wr_sched #(.GAP_CYC(2), .TIMEOUT_CYC(8)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .init_go   (init_go2),
        .bus       (bus2),
        .busy      (busy2),
        .init_done (init_done2),
        .err       (err2),
        .err_cnt   (err_cnt2)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] exp_q[$];
    logic [15:0] tbl[4] = '{16'h0E1C, 16'h0F00, 16'h0A00, 16'h0D00};
    int          start_cnt = 0;
    int          hang_txn  = -1;
    int          hang_len  = 0;
    int          cur_len   = 0;
    int          ack_cnt   = 0;
    int          cyc       = 0;
    int          over_cyc  = 0;
    bit          seen      = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (bus.ext_ack === 1'b1) ack_cnt++;

    // Engine model: pops the expected operands at each start, raises
    // eng_over after OVER_DELAY cycles unless this transaction is the hung one.
    initial begin
        logic [15:0] e;
        bus.eng_over = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.eng_start !== 1'b1) begin
                if (seen && start_cnt == hang_txn) hang_len = cur_len;
                seen         = 1'b0;
                bus.eng_over = 1'b0;
            end else begin
                if (!seen) begin
                    seen      = 1'b1;
                    start_cnt = start_cnt + 1;
                    cur_len   = 0;
                    check("sb_nonempty", exp_q.size() != 0, 1);
                    check("devaddr_at_start", bus.eng_devaddr, 8'hD0);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("wradd", bus.eng_wradd, e[15:8]);
                        check("wrdat", bus.eng_wrdat, e[7:0]);
                    end
                end
                cur_len = cur_len + 1;
                if (cur_len == OVER_DELAY && start_cnt != hang_txn) begin
                    bus.eng_over = 1'b1;
                    over_cyc     = cyc;
                end
            end
        end
    end

    task automatic pulse_init();
        @(negedge clk) init_go = 1'b1;
        @(negedge clk) init_go = 1'b0;
    endtask

    task automatic wait_init_done(input int bound, input string tag);
        int n = 0;
        while (init_done !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, n < bound, 1);
    endtask

    task automatic wait_ack(input int bound, input string tag);
        int n = 0;
        while (bus.ext_ack !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, n < bound, 1);
    endtask

    initial begin
        int n, s0, a0;
        init_go       = 1'b0;
        init_go2      = 1'b0;
        bus.ext_req   = 1'b0;
        bus.ext_addr  = 8'h00;
        bus.ext_dat   = 8'h00;
        bus2.ext_req  = 1'b0;
        bus2.ext_addr = 8'h00;
        bus2.ext_dat  = 8'h00;
        bus2.eng_over = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_outputs", {busy, init_done, err, err_cnt, bus.eng_start, bus.eng_wradd,
                              bus.eng_wrdat, bus.ext_ack, bus.ext_err}, 0);
        check("rst_devaddr", bus.eng_devaddr, 8'hD0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("no_auto_init_busy", busy, 0);
        check("no_auto_init_starts", start_cnt, 0);

        // init table, engine answers after 70 cycles
        foreach (tbl[i]) exp_q.push_back(tbl[i]);
        s0 = start_cnt;
        pulse_init();
        wait_init_done(2000, "init_wait");
        check("init_starts", start_cnt - s0, 4);
        check("init_done", init_done, 1);
        check("init_err", err, 0);
        check("init_sb_drained", exp_q.size(), 0);

        // single ext write while idle
        exp_q.push_back(16'h0512);
        s0 = start_cnt;
        a0 = ack_cnt;
        bus.ext_addr = 8'h05;
        bus.ext_dat  = 8'h12;
        bus.ext_req  = 1'b1;
        wait_ack(500, "ext_ack_wait");
        check("ext_err", bus.ext_err, 0);
        check("ext_gap_len", cyc - over_cyc, GAP);
        bus.ext_req = 1'b0;
        @(negedge clk);
        check("ext_busy_low", busy, 0);
        repeat (20) @(negedge clk);
        check("ext_ack_count", ack_cnt - a0, 1);
        check("ext_starts", start_cnt - s0, 1);

        // entry 2 never completes
        foreach (tbl[i]) exp_q.push_back(tbl[i]);
        s0 = start_cnt;
        hang_txn = start_cnt + 2;
        pulse_init();
        check("init_done_cleared", init_done, 0);
        wait_init_done(20000, "to_wait");
        check("to_start_len", hang_len, TMO);
        check("to_err", err, 1);
        check("to_err_cnt", err_cnt, 1);
        check("to_starts", start_cnt - s0, 4);
        check("to_init_done", init_done, 1);
        check("to_sb_drained", exp_q.size(), 0);
        hang_txn = -1;

        // ext_req during entry 1, held one cycle past ack
        foreach (tbl[i]) exp_q.push_back(tbl[i]);
        exp_q.push_back(16'h3344);
        s0 = start_cnt;
        a0 = ack_cnt;
        pulse_init();
        n = 0;
        while (start_cnt == s0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mix_first_start", n < 50, 1);
        bus.ext_addr = 8'h33;
        bus.ext_dat  = 8'h44;
        bus.ext_req  = 1'b1;
        wait_ack(3000, "mix_ack_wait");
        check("mix_ext_err", bus.ext_err, 0);
        check("mix_done_before_ext", init_done, 1);
        @(negedge clk);
        bus.ext_req = 1'b0;
        repeat (30) @(negedge clk);
        check("mix_ack_count", ack_cnt - a0, 1);
        check("mix_starts", start_cnt - s0, 5);
        check("mix_sb_drained", exp_q.size(), 0);
        check("mix_err_sticky", err, 1);
        check("mix_err_cnt", err_cnt, 1);

        // reset in the middle of WAIT
        exp_q.push_back(tbl[0]);
        s0 = start_cnt;
        pulse_init();
        n = 0;
        while (bus.eng_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rstw_reached_wait", n < 20, 1);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstw_start_low", bus.eng_start, 0);
        check("rstw_outputs", {busy, init_done, err, err_cnt, bus.eng_start, bus.eng_wradd,
                               bus.eng_wrdat, bus.ext_ack, bus.ext_err}, 0);
        @(negedge clk) rst = 1'b0;
        repeat (40) @(negedge clk);
        check("rstw_idle", busy, 0);
        check("rstw_starts", start_cnt - s0, 1);
        check("rstw_sb_drained", exp_q.size(), 0);

        // saturation: 4 timeouts per init round on the short-timeout instance
        for (int r = 1; r <= 65; r++) begin
            @(negedge clk) init_go2 = 1'b1;
            @(negedge clk) init_go2 = 1'b0;
            n = 0;
            while (init_done2 !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("sat_round_wait", n < 200, 1);
            check("sat_err_cnt", err_cnt2, (4 * r > 255) ? 255 : 4 * r);
        end
        check("sat_err", err2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
